// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the uart TX/RX scheduler.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HDR,
    ST_HDR_RISE,
    ST_HDR_FALL,
    ST_LOAD_DAT,
    ST_DAT_RISE,
    ST_DAT_FALL,
    ST_DONE
  } state_t;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  function automatic logic [7:0] hdr(input logic [2:0] id);
    return {HDR_MAGIC, 1'b0, id};
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the served requester when advance is pulsed.
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [2:0]         adv_id,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [2:0]         grant_idx,
  output logic               grant_valid
);

  logic [2:0] ptr_reg;
  logic [7:0] req_ext;
  logic [2:0] cand_idx [NUM_REQ];

  assign req_ext = 8'(req);

  // cand_idx[k] is the requester k places after the pointer, wrapped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [3:0] sum;
    assign sum          = {1'b0, ptr_reg} + 4'(gi);
    assign cand_idx[gi] = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    // Scan from the far end so the closest candidate is assigned last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_ext[cand_idx[k]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
    grant_oh = grant_valid ? NUM_REQ'(8'b1 << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg <= 3'd0;
    end else if (advance) begin
      ptr_reg <= (adv_id == 3'(NUM_REQ - 1)) ? 3'd0 : adv_id + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart between NUM_REQ byte requesters (round-robin TX with an
// optional ID header) and turns the uart RX ready/dout into a valid strobe.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HDR_EN       = 1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [7:0]           uart_din,
  output logic                 uart_wr_en,
  input  logic                 uart_tx_busy,
  input  logic                 uart_ready,
  input  logic [7:0]           uart_dout,
  output logic                 uart_rx_clr,
  output logic [7:0]           rx_data,
  output logic                 rx_valid
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic [2:0]           grant_id_reg;
  logic [NUM_REQ-1:0]   grant_oh_reg;
  logic [7:0]           data_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 timeout_err_reg;
  logic                 timeout_set;
  logic                 in_rise;
  logic                 take;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [2:0]           arb_idx;
  logic                 arb_valid;
  logic [7:0]           req_bytes [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    if (gi < NUM_REQ) begin : g_used
      assign req_bytes[gi] = req_data[8*gi +: 8];
    end else begin : g_unused
      assign req_bytes[gi] = 8'h00;
    end
  end

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .advance     (state_reg == ST_DONE),
    .adv_id      (grant_id_reg),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  assign take    = (state_reg == ST_IDLE) && arb_valid && !uart_tx_busy;
  assign in_rise = (state_reg == ST_HDR_RISE) || (state_reg == ST_DAT_RISE);

  always_comb begin
    state_next  = state_reg;
    timeout_set = 1'b0;
    uart_wr_en  = 1'b0;
    uart_din    = 8'h00;
    ack         = '0;
    busy        = (state_reg != ST_IDLE);
    grant_id    = grant_id_reg;
    timeout_err = timeout_err_reg;
    case (state_reg)
      ST_IDLE:     if (take) state_next = (HDR_EN != 0) ? ST_LOAD_HDR : ST_LOAD_DAT;
      ST_LOAD_HDR: begin
        uart_wr_en = 1'b1;
        uart_din   = hdr(grant_id_reg);
        state_next = ST_HDR_RISE;
      end
      ST_HDR_RISE: begin
        if (uart_tx_busy) begin
          state_next = ST_HDR_FALL;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = ST_DONE;
          timeout_set = 1'b1;
        end
      end
      ST_HDR_FALL: if (!uart_tx_busy) state_next = ST_LOAD_DAT;
      ST_LOAD_DAT: begin
        uart_wr_en = 1'b1;
        uart_din   = data_reg;
        state_next = ST_DAT_RISE;
      end
      ST_DAT_RISE: begin
        if (uart_tx_busy) begin
          state_next = ST_DAT_FALL;
        end else if (cnt_reg == CNT_LAST) begin
          state_next  = ST_DONE;
          timeout_set = 1'b1;
        end
      end
      ST_DAT_FALL: if (!uart_tx_busy) state_next = ST_DONE;
      ST_DONE: begin
        ack        = grant_oh_reg;
        state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      grant_id_reg    <= 3'd0;
      grant_oh_reg    <= '0;
      data_reg        <= 8'h00;
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        grant_id_reg <= arb_idx;
        grant_oh_reg <= arb_oh;
        data_reg     <= req_bytes[arb_idx];
      end
      // Counts busy-rise wait cycles; held at zero outside the RISE states.
      cnt_reg <= in_rise ? cnt_reg + CNT_W'(1) : '0;
      if (timeout_set) timeout_err_reg <= 1'b1;
    end
  end

  // RX capture: the clear flag blocks re-capture until ready has gone low.
  logic rx_clr_flag_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data         <= 8'h00;
      rx_valid        <= 1'b0;
      uart_rx_clr     <= 1'b0;
      rx_clr_flag_reg <= 1'b0;
    end else if (uart_ready && !rx_clr_flag_reg) begin
      rx_data         <= uart_dout;
      rx_valid        <= 1'b1;
      uart_rx_clr     <= 1'b1;
      rx_clr_flag_reg <= 1'b1;
    end else begin
      rx_valid    <= 1'b0;
      uart_rx_clr <= 1'b0;
      if (!uart_ready) rx_clr_flag_reg <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Sequences the shared uart block between NUM_REQ byte requesters.
- TX side: round-robin arbitration; the granted byte (optionally preceded by a header byte carrying the requester ID) is driven onto the uart din/wr_en, and tx_busy is tracked until the frame completes.
- RX side: the uart ready/dout pair is captured into a one-cycle valid strobe, and the receiver is cleared through its reset input.
- Sits directly above uart, between the system request bus and the uart pins.

Parameters:
NUM_REQ, 4, number of TX requesters (2..8)
HDR_EN, 1, 1 = send header byte {4'hA, 1'b0, id[2:0]} before each data byte; 0 = data byte only
BUSY_TIMEOUT, 16, cycles allowed after a wr_en pulse for uart_tx_busy to rise (must be >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
req  in  NUM_REQ  per-requester request level; held until the matching ack
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]; stable while req[i]=1
ack  out  NUM_REQ  one-cycle pulse to the requester whose frame finished (or aborted)
grant_id  out  3  index of the current or last granted requester
busy  out  1  1 whenever the FSM is not in IDLE
timeout_err  out  1  sticky; set on a busy-rise timeout; cleared only by reset
uart_din  out  8  byte to the uart transmitter
uart_wr_en  out  1  one-cycle write strobe to the uart transmitter
uart_tx_busy  in  1  uart transmitter busy flag
uart_ready  in  1  uart receiver byte-available flag
uart_dout  in  8  uart received byte
uart_rx_clr  out  1  drives the uart receiver reset; pulse clears ready
rx_data  out  8  captured received byte
rx_valid  out  1  one-cycle strobe; rx_data is valid in the same cycle

Behaviour:
- Reset values (reset=0 at a clk edge): FSM=IDLE, ack=0, grant_id=0, busy=0, timeout_err=0, uart_din=0, uart_wr_en=0, uart_rx_clr=0, rx_data=0, rx_valid=0, round-robin pointer=0.
- Reset mid-frame: the FSM aborts immediately with no ack. The uart may still finish shifting the byte already loaded.
- FSM states: IDLE, LOAD_HDR, HDR_RISE, HDR_FALL, LOAD_DAT, DAT_RISE, DAT_FALL, DONE.
- IDLE:
  - If any req=1 and uart_tx_busy=0: grant the first requester at or after the pointer (wrap at NUM_REQ-1 -> 0).
  - Latch grant_id and the byte.
  - Go to LOAD_HDR if HDR_EN, else LOAD_DAT.
  - If uart_tx_busy=1, remain in IDLE.
- LOAD_x: uart_wr_en=1 for exactly one cycle, with uart_din = header or latched byte. Next state is x_RISE, with the timeout counter cleared.
- x_RISE:
  - uart_tx_busy=1 -> x_FALL.
  - Counter reaches BUSY_TIMEOUT -> set timeout_err, go to DONE (aborted frame).
- x_FALL: wait for uart_tx_busy=0, with no timeout. HDR_FALL -> LOAD_DAT; DAT_FALL -> DONE.
- DONE:
  - ack[grant_id]=1 for one cycle.
  - pointer = grant_id+1 (wrapping).
  - Go to IDLE.
  - An aborted frame is acked identically; software checks timeout_err.
- Latency: from req seen in IDLE to uart_wr_en high is 1 cycle.
- Back-to-back frames: a new grant is possible in the cycle after DONE.
- Fairness:
  - A requester that drops req before grant is skipped.
  - req changing after grant is ignored; the byte is already latched.
  - A requester keeping req high after its ack is re-served only after every other pending requester.
- RX path, independent of TX:
  - On uart_ready=1 while the internal clear flag=0: rx_data<=uart_dout, rx_valid=1 for one cycle, uart_rx_clr=1 for one cycle (same cycle as rx_valid), clear flag set.
  - The clear flag drops once uart_ready=0. This prevents duplicate capture while ready is still decaying.
- Widths: the timeout counter is $clog2(BUSY_TIMEOUT+1) bits. grant_id is zero-extended to 3 bits.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - FSM state enum
  - HDR_MAGIC = 4'hA
  - the header-format function hdr(id)
- One sub-module: uart_rr_arbiter (req vector, pointer -> one-hot grant + index), combinational plus pointer register.
- RX capture stays inline.

Test Plan:
- HDR_EN=1, req[2]=1 with data 8'h5C, uart_tx_busy modelled 2 cycles after wr_en for 10 cycles -> wr_en pulses with din 8'hA2 then 8'h5C; ack[2] pulses once; grant_id=2.
- req=4'b1011 held continuously -> grant order 0,1,3,0,1,3…; every ack is separated by a full frame.
- uart_tx_busy never rises after wr_en -> after 16 cycles timeout_err=1 and ack pulses; a following request still proceeds; timeout_err stays 1.
- uart_ready held high 5 cycles with dout 8'h3E -> exactly one rx_valid with rx_data=8'h3E and one uart_rx_clr pulse.
- reset=0 asserted in DAT_FALL -> next cycle all outputs are at reset values, no ack; after release, a pending req restarts from pointer 0.
- HDR_EN=0, req[1] and req[3] assert in the same cycle as an RX capture -> TX and RX proceed independently; req[1] is served first; rx_valid is unaffected.
